pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, squashes wrong-path instructions on a taken branch, and freezes the whole pipeline while the data memory is busy. It also keeps stall and flush performance counters and a watchdog on memory waits.

## Interface
- MEM_TIMEOUT, default 15: maximum consecutive MEM_WAIT cycles before the controller enters ERROR; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears state, counters and the error flag
- MemRead_EX  in  1  ID/EX stage holds a load
- RD_EX  in  5  destination register of the ID/EX stage
- RS1_ID, RS2_ID  in  5 each  source registers of the instruction in IF/ID
- rs2_used_ID  in  1  instruction in IF/ID reads rs2 (R/S/B-type)
- branch_taken_EX  in  1  branch in EX resolved taken
- mem_req_MEM  in  1  EX/MEM stage holds a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write  out  1 each  register write enables
- IF_ID_flush, ID_EX_flush  out  1 each  load a bubble (all zeros) into that register on the next edge
- stall  out  1  a stall or freeze is active this cycle
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  32  count of stall/freeze cycles
- flush_count  out  32  count of taken-branch flushes

## Operation
- FSM states are RUN, MEM_WAIT and ERROR. Reset enters RUN.
- **load_use** = MemRead_EX and RD_EX≠0 and (RD_EX==RS1_ID or (rs2_used_ID and RD_EX==RS2_ID)).
- **freeze** = mem_req_MEM and not dmem_ready, evaluated in RUN or MEM_WAIT.
- Outputs are combinational from the state and current inputs. The priority is ERROR > freeze > branch_taken_EX > load_use > normal.
  - **ERROR:** all writes 0, all flushes 0, stall=1.
  - **freeze:** all five writes 0, flushes 0, stall=1.
  - **branch taken:** all writes 1, IF_ID_flush=1 and ID_EX_flush=1, stall=0. Any concurrent load_use is ignored because its instruction is squashed.
  - **load_use:** PC_write=0 and IF_ID_write=0. ID_EX_write=1 with ID_EX_flush=1 (bubble). EX_MEM_write=1, MEM_WB_write=1, stall=1.
  - **normal:** all writes 1, flushes 0, stall=0.
- Transitions:
  - RUN→MEM_WAIT on freeze.
  - MEM_WAIT→RUN when dmem_ready=1.
  - MEM_WAIT→ERROR when the wait counter reaches MEM_TIMEOUT with dmem_ready still 0.
  - ERROR is left only by reset.
- The wait counter is 8 bits. It clears on entering MEM_WAIT and counts each MEM_WAIT cycle.
- A branch_taken_EX held during a freeze is applied in the first cycle after the freeze. The EX stage is frozen, so the flush is not lost.
- stall_cycles increments on every cycle with stall=1. flush_count increments on every cycle applying a branch flush. Both wrap modulo 2^32.
- mem_timeout is set on entering ERROR and stays set until reset.

## Timing
- Reset values: state RUN, wait counter 0, stall_cycles 0, flush_count 0, mem_timeout 0.
- While reset is high, all writes, both flushes and stall are forced to 0.
- Load-use costs exactly one bubble cycle. In the next cycle RD_EX holds the bubble (0), so load_use deasserts without extra state.
- A taken branch costs 2 squashed instructions and has zero stall cycles.
- Freeze costs N cycles for an access that asserts dmem_ready N cycles late. A ready access in the same cycle (dmem_ready=1 together with mem_req_MEM) costs 0 cycles.
- ERROR timing: with MEM_TIMEOUT=T, the first MEM_WAIT cycle counts 1. ERROR is entered on the edge after the T-th MEM_WAIT cycle if dmem_ready has stayed low.
- Reset asserted mid-wait returns the FSM to RUN asynchronously. Counters clear immediately.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - FSM state encoding: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10.
  - Counter width constant: 32.
  - Register-zero constant: 5'd0.
- One sub-module, `load_use_detect`: purely combinational comparison of RD_EX against RS1_ID/RS2_ID, reusable by the forwarding unit.
- The FSM, the wait counter and both performance counters live in the top module.

## Test plan
- **Load-use:** lw x5 in EX (MemRead_EX=1, RD_EX=5), RS1_ID=5 → one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cycles goes 0→1.
- **x0 and unused rs2:** RD_EX=0 with RS1_ID=0 → no stall. RD_EX=7, RS2_ID=7, rs2_used_ID=0 → no stall.
- **Branch and load-use together:** branch_taken_EX=1 plus load_use → all writes 1, IF_ID_flush=ID_EX_flush=1, stall=0; flush_count=1.
- **Memory wait:** mem_req_MEM=1, dmem_ready low for 3 cycles → 3 cycles with all writes 0; state returns to RUN when dmem_ready=1; stall_cycles=3.
- **Timeout:** MEM_TIMEOUT=4, dmem_ready held 0 → ERROR after 4 wait cycles; mem_timeout=1 sticky; async reset mid-ERROR clears everything.
- **Counter wrap:** preload or force stall_cycles=32'hFFFFFFFF, then one stall → 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_t;

  localparam int          CNT_W    = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Per-cycle control bundle driven onto the pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic stall;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = '0;
  localparam ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use check of the EX-stage load destination against ID sources.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       MemRead_EX,
  input  logic [4:0] RD_EX,
  input  logic [4:0] RS1_ID,
  input  logic [4:0] RS2_ID,
  input  logic       rs2_used_ID,
  output logic       load_use
);
  // x0 is never a real dependency, so it must not stall.
  assign load_use = MemRead_EX && (RD_EX != REG_ZERO) &&
                    ((RD_EX == RS1_ID) || (rs2_used_ID && (RD_EX == RS2_ID)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing: load-use bubbles, branch squash, memory freeze,
// memory-wait watchdog and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             rs2_used_ID,
  input  logic             branch_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_inc;
  logic       load_use, freeze, br_apply;
  ctrl_t      ctrl;

  load_use_detect u_lud (
    .MemRead_EX  (MemRead_EX),
    .RD_EX       (RD_EX),
    .RS1_ID      (RS1_ID),
    .RS2_ID      (RS2_ID),
    .rs2_used_ID (rs2_used_ID),
    .load_use    (load_use)
  );

  assign freeze   = (state != ST_ERROR) && mem_req_MEM && !dmem_ready;
  assign wait_inc = wait_cnt + 8'd1;

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:      if (freeze) state_nx = ST_MEM_WAIT;
      // wait_inc is the ordinal of the current MEM_WAIT cycle (first = 1).
      ST_MEM_WAIT: if (dmem_ready)           state_nx = ST_RUN;
                   else if (wait_inc >= TIMEOUT) state_nx = ST_ERROR;
      ST_ERROR:    state_nx = ST_ERROR;
      default:     state_nx = ST_RUN;
    endcase
  end

  // Freeze outranks the branch, so a held branch_taken_EX flushes right after it.
  always_comb begin
    ctrl     = CTRL_NORMAL;
    br_apply = 1'b0;
    if (reset)                 ctrl = CTRL_IDLE;
    else if (state == ST_ERROR) ctrl = CTRL_HOLD;
    else if (freeze)            ctrl = CTRL_HOLD;
    else if (branch_taken_EX) begin
      ctrl     = CTRL_BRANCH;
      br_apply = 1'b1;
    end
    else if (load_use)          ctrl = CTRL_BUBBLE;
  end

  assign PC_write     = ctrl.pc_write;
  assign IF_ID_write  = ctrl.if_id_write;
  assign ID_EX_write  = ctrl.id_ex_write;
  assign EX_MEM_write = ctrl.ex_mem_write;
  assign MEM_WB_write = ctrl.mem_wb_write;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_flush  = ctrl.id_ex_flush;
  assign stall        = ctrl.stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      wait_cnt     <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_RUN && freeze) wait_cnt <= 8'd0;
      else if (state == ST_MEM_WAIT) wait_cnt <= wait_inc;
      if (state_nx == ST_ERROR) mem_timeout <= 1'b1;
      stall_cycles <= stall_cycles + CNT_W'(ctrl.stall);
      flush_count  <= flush_count + CNT_W'(br_apply);
    end
  end
endmodule
